crc_stream: RTL

Parametrised streaming CRC engine, the generalised successor of the fixed-polynomial byte CRC-8 block.
- Configurable CRC width, polynomial, init, output XOR, bit reflection and input beat width.
- Framed valid/ready input with end-of-frame marker; holds the final CRC on a valid/ready result port until it is consumed.
- Sits between a packet source (UART/SPI framer) and the consumer that appends or checks the CRC.

---
 rtl/crc_stream.sv | 63 ++++++
 1 files changed

// File: rtl/crc_stream.sv
// crc_stream: framed streaming CRC engine with configurable polynomial, reflection and beat width
module crc_stream #(
  parameter int CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT = '0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT = '0,
  parameter bit REFLECT_IN = 1'b0,
  parameter bit REFLECT_OUT = 1'b0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic [CRC_WIDTH-1:0]  crc_o,
  output logic                  crc_valid_o,
  input  logic                  crc_ready_i
);
  localparam int LANES = DATA_WIDTH / 8;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [CRC_WIDTH-1:0] crc, crc_nxt, crc_rev, result;
  logic [7:0] b;
  logic fb;
  logic accept;
  assign s_ready_o = rst_ni & (state == ACCUM);
  assign accept = s_valid_i & s_ready_o;
  assign crc_valid_o = state == HOLD;
  assign result = (REFLECT_OUT ? crc_rev : crc_nxt) ^ XOR_OUT;
  always_comb begin
    crc_nxt = crc;
    b = '0;
    fb = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      b = s_data_i[8*k +: 8];
      for (int j = 7; j >= 0; j--) begin
        fb = crc_nxt[CRC_WIDTH-1] ^ (REFLECT_IN ? b[7-j] : b[j]);
        crc_nxt = (crc_nxt << 1) ^ (fb ? POLYNOMIAL : '0);
      end
    end
  end
  always_comb begin
    crc_rev = '0;
    for (int j = 0; j < CRC_WIDTH; j++) crc_rev[j] = crc_nxt[CRC_WIDTH-1-j];
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == ACCUM) ? ((accept & s_last_i) ? HOLD : ACCUM) : (crc_ready_i ? ACCUM : HOLD);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ACCUM;
      crc <= INIT;
      crc_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) crc <= s_last_i ? INIT : crc_nxt;
      if (accept & s_last_i) crc_o <= result;
    end
  end
endmodule
